// File: rtl/game_pkg.sv
// Shared game definitions: state encodings and playfield/sprite geometry
// used by the player controller and the renderer.
package game_pkg;

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8,
    ST_HELP     = 4'd9
  } game_state_e;

  typedef enum logic {
    ANIM_IDLE = 1'b0,
    ANIM_WALK = 1'b1
  } anim_mode_e;

  localparam int PLAY_W   = 320;
  localparam int PLAY_H   = 240;
  localparam int SPRITE_W = 10;
  localparam int SPRITE_H = 10;

endpackage

// File: rtl/anim_counter.sv
// Per-character animation frame counter: a tick divider that steps a
// frame index modulo FRAMES every ANIM_DIV enabled ticks.
module anim_counter #(
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] frame
);

  localparam logic [7:0] DIV_LAST   = 8'(ANIM_DIV - 1);
  localparam logic [3:0] FRAME_LAST = 4'(FRAMES - 1);

  logic [7:0] r_div;
  logic [3:0] r_frame;

  // clr is immediate; callers gate it with tick when they want a tick-aligned clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_div   <= 8'd0;
      r_frame <= 4'd0;
    end else if (tick && en) begin
      if (r_div == DIV_LAST) begin
        r_div   <= 8'd0;
        r_frame <= (r_frame == FRAME_LAST) ? 4'd0 : r_frame + 4'd1;
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  assign frame = r_frame;

endmodule

// File: rtl/player_ctrl.sv
// Player position, per-character animation frames and unlock mask,
// all advancing on the per-frame tick.
module player_ctrl
  import game_pkg::*;
#(
  parameter int STEP     = 1,
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  parameter int SPAWN_X  = 10,
  parameter int SPAWN_Y  = 115,
  parameter int X_MAX    = PLAY_W - SPRITE_W,
  parameter int Y_MAX    = PLAY_H - SPRITE_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic        tick,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic [8:0]  player_x,
  output logic [8:0]  player_y,
  output logic [11:0] player_state,
  output logic [3:0]  play_valid
);

  localparam logic signed [9:0] STEP_S  = 10'(STEP);
  localparam logic signed [9:0] X_MAX_S = 10'(X_MAX);
  localparam logic signed [9:0] Y_MAX_S = 10'(Y_MAX);
  localparam logic [8:0]        SPAWN_XV = 9'(SPAWN_X);
  localparam logic [8:0]        SPAWN_YV = 9'(SPAWN_Y);

  function automatic logic [8:0] clamp_axis(input logic signed [9:0] v,
                                            input logic signed [9:0] vmax);
    if (v < 10'sd0)       return 9'd0;
    else if (v > vmax)    return vmax[8:0];
    else                  return v[8:0];
  endfunction

  logic [3:0]  r_prev_state;
  logic [8:0]  r_x, r_y;
  logic [3:0]  r_valid;

  logic        w_entry;
  logic        w_in_stage;
  logic [1:0]  w_stage_k;
  logic        w_attract;
  anim_mode_e  w_mode;
  logic signed [9:0] w_dx, w_dy, w_nx, w_ny;
  logic [2:0]  w_en, w_clr;
  logic [3:0]  w_frame [3];

  assign w_entry = (state != r_prev_state);

  always_comb begin
    w_in_stage = 1'b0;
    w_stage_k  = 2'd0;
    w_attract  = 1'b0;
    case (state)
      ST_STAGE1: begin w_in_stage = 1'b1; w_stage_k = 2'd1; end
      ST_STAGE2: begin w_in_stage = 1'b1; w_stage_k = 2'd2; end
      ST_STAGE3: begin w_in_stage = 1'b1; w_stage_k = 2'd3; end
      ST_TITLE, ST_STAFF, ST_SUCCESS1, ST_SUCCESS2, ST_SUCCESS3: w_attract = 1'b1;
      default: ;
    endcase
  end

  // Opposing keys cancel; walking means at least one axis has a net direction
  always_comb begin
    w_dx = 10'sd0;
    w_dy = 10'sd0;
    if (key_right && !key_left) w_dx = STEP_S;
    if (key_left && !key_right) w_dx = -STEP_S;
    if (key_down && !key_up)    w_dy = STEP_S;
    if (key_up && !key_down)    w_dy = -STEP_S;
    w_mode = ((key_left ^ key_right) || (key_up ^ key_down)) ? ANIM_WALK : ANIM_IDLE;
    w_nx = $signed({1'b0, r_x}) + w_dx;
    w_ny = $signed({1'b0, r_y}) + w_dy;
  end

  always_comb begin
    w_en  = 3'b000;
    w_clr = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (w_attract) begin
        w_en[k] = 1'b1;
      end else if (w_in_stage && (w_stage_k == 2'(k + 1))) begin
        w_en[k]  = !w_entry && (w_mode == ANIM_WALK);
        w_clr[k] = w_entry || (tick && (w_mode == ANIM_IDLE));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_state <= ST_TITLE;
      r_x          <= SPAWN_XV;
      r_y          <= SPAWN_YV;
      r_valid      <= 4'b0010;
    end else begin
      r_prev_state <= state;
      if (w_in_stage && w_entry) begin
        r_x <= SPAWN_XV;
        r_y <= SPAWN_YV;
      end else if (w_in_stage && tick) begin
        r_x <= clamp_axis(w_nx, X_MAX_S);
        r_y <= clamp_axis(w_ny, Y_MAX_S);
      end
      if (w_entry && (state == ST_SUCCESS1)) r_valid[2] <= 1'b1;
      if (w_entry && (state == ST_SUCCESS2)) r_valid[3] <= 1'b1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_anim
    anim_counter #(
      .FRAMES   (FRAMES),
      .ANIM_DIV (ANIM_DIV)
    ) u_anim (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .en    (w_en[g]),
      .clr   (w_clr[g]),
      .frame (w_frame[g])
    );
  end

  assign player_x     = r_x;
  assign player_y     = r_y;
  assign player_state = {w_frame[2], w_frame[1], w_frame[0]};
  assign play_valid   = r_valid;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: a table of state/key/tick-count vectors with
// hand-derived expectations, plus reset and same-edge entry sequences.
module tb_player_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  state;
  logic        tick;
  logic        key_up, key_down, key_left, key_right;
  logic [8:0]  player_x, player_y;
  logic [11:0] player_state;
  logic [3:0]  play_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  player_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .tick         (tick),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .player_x     (player_x),
    .player_y     (player_y),
    .player_state (player_state),
    .play_valid   (play_valid)
  );

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [3:0] keys;   // {up, down, left, right}
    int         ticks;
    logic [8:0] ex;
    logic [8:0] ey;
    logic [11:0] eps;
    logic [3:0] epv;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] ex;
    logic [8:0] ey;
    logic [11:0] eps;
    logic [3:0] epv;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
  endtask

  task automatic expect_push(input string n, input logic [8:0] x, input logic [8:0] y,
                             input logic [11:0] ps, input logic [3:0] pv);
    exp_t e;
    e.name = n; e.ex = x; e.ey = y; e.eps = ps; e.epv = pv;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
      return;
    end
    e = sb.pop_front();
    n_tests += 4;
    if (player_x !== e.ex) begin
      n_fail++; $display("FAIL %s.x: got %0d, required %0d", e.name, player_x, e.ex);
    end
    if (player_y !== e.ey) begin
      n_fail++; $display("FAIL %s.y: got %0d, required %0d", e.name, player_y, e.ey);
    end
    if (player_state !== e.eps) begin
      n_fail++; $display("FAIL %s.player_state: got %h, required %h", e.name, player_state, e.eps);
    end
    if (play_valid !== e.epv) begin
      n_fail++; $display("FAIL %s.play_valid: got %b, required %b", e.name, play_valid, e.epv);
    end
  endtask

  initial begin
    // keys: {up, down, left, right}
    vecs[0]  = '{"stage1_idle",   4'd2, 4'b0000, 20,  9'd10, 9'd115, 12'h000, 4'b0010};
    vecs[1]  = '{"right5",        4'd2, 4'b0001, 5,   9'd15, 9'd115, 12'h000, 4'b0010};
    vecs[2]  = '{"right16",       4'd2, 4'b0001, 11,  9'd26, 9'd115, 12'h002, 4'b0010};
    vecs[3]  = '{"idle_clear",    4'd2, 4'b0000, 1,   9'd26, 9'd115, 12'h000, 4'b0010};
    vecs[4]  = '{"stage2_lr_up",  4'd4, 4'b1011, 10,  9'd10, 9'd105, 12'h010, 4'b0010};
    vecs[5]  = '{"left_to_0",     4'd4, 4'b0010, 20,  9'd0,  9'd105, 12'h030, 4'b0010};
    vecs[6]  = '{"left_hold0",    4'd4, 4'b0010, 5,   9'd0,  9'd105, 12'h000, 4'b0010};
    vecs[7]  = '{"down_ymax",     4'd4, 4'b0100, 130, 9'd0,  9'd230, 12'h000, 4'b0010};
    vecs[8]  = '{"success1",      4'd3, 4'b0000, 0,   9'd0,  9'd230, 12'h000, 4'b0110};
    vecs[9]  = '{"stage2_reent",  4'd4, 4'b0000, 0,   9'd10, 9'd115, 12'h000, 4'b0110};
    vecs[10] = '{"success2_attr", 4'd5, 4'b0000, 8,   9'd10, 9'd115, 12'h111, 4'b1110};
    vecs[11] = '{"title_sticky",  4'd0, 4'b0000, 0,   9'd10, 9'd115, 12'h111, 4'b1110};
    vecs[12] = '{"fail_frozen",   4'd8, 4'b0001, 10,  9'd10, 9'd115, 12'h111, 4'b1110};

    rst = 1'b1; state = 4'd0; tick = 1'b0; set_keys(4'b0000);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    expect_push("reset", 9'd10, 9'd115, 12'h000, 4'b0010);
    check_pop();

    foreach (vecs[i]) begin
      state = vecs[i].st;
      set_keys(vecs[i].keys);
      cyc();
      for (int t = 0; t < vecs[i].ticks; t++) do_tick();
      expect_push(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].eps, vecs[i].epv);
      check_pop();
    end

    // Synchronous reset clears the sticky unlock bits
    set_keys(4'b0000);
    state = 4'd0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_push("rst_unlock", 9'd10, 9'd115, 12'h000, 4'b0010);
    check_pop();

    // Entry into STAGE3 coincident with a tick: spawn wins over motion
    state = 4'd6;
    set_keys(4'b0001);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    expect_push("entry_tick", 9'd10, 9'd115, 12'h000, 4'b0010);
    check_pop();

    for (int t = 0; t < 10; t++) do_tick();
    expect_push("stage3_move", 9'd20, 9'd115, 12'h100, 4'b0010);
    check_pop();

    // Reset on a tick edge while moving beats the motion update
    rst = 1'b1;
    tick = 1'b1;
    cyc();
    rst = 1'b0;
    tick = 1'b0;
    state = 4'd0;
    set_keys(4'b0000);
    expect_push("rst_on_tick", 9'd10, 9'd115, 12'h000, 4'b0010);
    check_pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
